// File: rtl/vga_pkg.sv
// Shared types, default 640x480 timing and helpers for the VGA display and capture blocks.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_GRAY    = 2'd0,
        MODE_EDGE    = 2'd1,
        MODE_RED     = 2'd2,
        MODE_OVERLAY = 2'd3
    } mode_e;

    localparam int CNT_W = 12;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Per-pixel timing flags that travel alongside the memory read.
    typedef struct packed {
        logic in_win;
        logic blank;
        logic hs_n;
        logic vs_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{in_win: 1'b0, blank: 1'b1, hs_n: 1'b1, vs_n: 1'b1};

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with raw active-low syncs, blank and frame-start flags.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             pixel_clk,
    input  logic             reset,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             hs_n,
    output logic             vs_n,
    output logic             blank,
    output logic             frame_start
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_size_err
        $error("vga_timing_gen: raster does not fit the counter width");
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + ONE;
        end else begin
            h <= h + ONE;
        end
    end

    assign hs_n        = !((h >= HS_START) && (h < HS_END));
    assign vs_n        = !((v >= VS_START) && (v < VS_END));
    assign blank       = (h >= CNT_W'(H_ACTIVE)) || (v >= CNT_W'(V_ACTIVE));
    assign frame_start = (h == '0) && (v == '0);

endmodule

// File: rtl/vga_window_display.sv
// Windowed VGA scan-out: address generation, latency-matched sync delay and mode colour mux.
// Optional checkerboard source replacing memory pixels when VGA_TEST_PATTERN_EN is defined.
module vga_window_display
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int WIN_X0   = 20,
    parameter int WIN_X1   = 620,
    parameter int WIN_Y0   = 40,
    parameter int WIN_Y1   = 440,
    parameter int PIX_W    = 4,
    parameter int MEM_LAT  = 1,
    parameter int EDGE_THR = 8
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] vga_in,
    input  logic [PIX_W-1:0] vga_in_edge,
    input  logic [1:0]       mode,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_pattern,
`endif
    output logic [9:0]       out_x,
    output logic [8:0]       out_y,
    output logic             rd_en,
    output logic             frame_start,
    output logic [PIX_W-1:0] VGA_R,
    output logic [PIX_W-1:0] VGA_G,
    output logic [PIX_W-1:0] VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS
);

    if (WIN_X1 > H_ACTIVE || WIN_Y1 > V_ACTIVE || MEM_LAT > 4 || MEM_LAT < 0) begin : g_param_err
        $error("vga_window_display: window exceeds active area or MEM_LAT out of range");
    end

    localparam logic [CNT_W-1:0] X0_C = CNT_W'(WIN_X0);
    localparam logic [CNT_W-1:0] X1_C = CNT_W'(WIN_X1);
    localparam logic [CNT_W-1:0] Y0_C = CNT_W'(WIN_Y0);
    localparam logic [CNT_W-1:0] Y1_C = CNT_W'(WIN_Y1);

    logic [CNT_W-1:0] h, v;
    logic             hs_n, vs_n, blank, fs_raw;
    logic             in_win, rd_next;
    logic [9:0]       x_next;
    logic [8:0]       y_next;
    sync_t            raw;
    sync_t            dl [MEM_LAT+1];
    mode_e            mode_q;
    logic [PIX_W-1:0] gray, edge_px, r_n, g_n, b_n;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .pixel_clk  (pixel_clk),
        .reset      (reset),
        .h          (h),
        .v          (v),
        .hs_n       (hs_n),
        .vs_n       (vs_n),
        .blank      (blank),
        .frame_start(fs_raw)
    );

    assign in_win  = (h >= X0_C) && (h < X1_C) && (v >= Y0_C) && (v < Y1_C);
    assign rd_next = in_win && !blank;
    assign x_next  = rd_next ? 10'(h - X0_C) : '0;
    assign y_next  = rd_next ? 9'(v - Y0_C) : '0;
    assign raw     = '{in_win: in_win, blank: blank, hs_n: hs_n, vs_n: vs_n};

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            rd_en       <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            rd_en       <= rd_next;
            out_x       <= x_next;
            out_y       <= y_next;
            frame_start <= fs_raw;
        end
    end

    // dl[0] is aligned with the address register; dl[MEM_LAT] lines up with returning data.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            for (int i = 0; i <= MEM_LAT; i++) dl[i] <= SYNC_IDLE;
        end else begin
            dl[0] <= raw;
            for (int i = 1; i <= MEM_LAT; i++) dl[i] <= dl[i-1];
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset)            mode_q <= MODE_GRAY;
        else if (frame_start) mode_q <= mode_e'(mode);
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [9:0] dx [MEM_LAT+1];
    logic [8:0] dy [MEM_LAT+1];
    logic       tp_bit;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                dx[i] <= '0;
                dy[i] <= '0;
            end
        end else begin
            dx[0] <= x_next;
            dy[0] <= y_next;
            for (int i = 1; i <= MEM_LAT; i++) begin
                dx[i] <= dx[i-1];
                dy[i] <= dy[i-1];
            end
        end
    end

    assign tp_bit = dx[MEM_LAT][4] ^ dy[MEM_LAT][4];
`endif

    always_comb begin
        gray    = vga_in;
        edge_px = vga_in_edge;
`ifdef VGA_TEST_PATTERN_EN
        if (test_pattern) begin
            gray    = {PIX_W{tp_bit}};
            edge_px = {PIX_W{tp_bit}};
        end
`endif
        r_n = '0;
        g_n = '0;
        b_n = '0;
        if (dl[MEM_LAT].in_win && !dl[MEM_LAT].blank) begin
            case (mode_q)
                MODE_GRAY: begin r_n = gray;    g_n = gray;    b_n = gray;    end
                MODE_EDGE: begin r_n = edge_px; g_n = edge_px; b_n = edge_px; end
                MODE_RED:  begin r_n = gray;    g_n = gray >> 1; b_n = gray >> 1; end
                default: begin
                    if (edge_px >= PIX_W'(EDGE_THR)) begin
                        r_n = '1;
                    end else begin
                        r_n = gray; g_n = gray; b_n = gray;
                    end
                end
            endcase
        end
    end

    // Colour and syncs leave the same register so the connector sees them aligned.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
        end else begin
            VGA_R  <= r_n;
            VGA_G  <= g_n;
            VGA_B  <= b_n;
            VGA_HS <= dl[MEM_LAT].hs_n;
            VGA_VS <= dl[MEM_LAT].vs_n;
        end
    end

endmodule
